// File: rtl/status_pkg.sv
// status_pkg: shared width, FSM encoding and requester indices for status_ctrl.
// Contents:
//   STATUS_W          width of every status value (score, life, level)
//   ST_IDLE/EXEC/ACK  FSM state encodings, also exposed as state_e
//   req_idx_e         round-robin requester index (score, life, level)
//   rr_step()         next requester index in round-robin order
package status_pkg;

    localparam int STATUS_W = 13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_EXEC = ST_EXEC,
        S_ACK  = ST_ACK
    } state_e;

    typedef enum logic [1:0] {
        REQ_SCORE = 2'd0,
        REQ_LIFE  = 2'd1,
        REQ_LVL   = 2'd2
    } req_idx_e;

    function automatic req_idx_e rr_step(input req_idx_e r);
        return (r == REQ_LVL) ? REQ_SCORE : req_idx_e'(r + 2'd1);
    endfunction

endpackage

// File: rtl/status_ctrl_if.sv
// status_ctrl_if: 4-phase req/ack bundle between game-logic requesters and status_ctrl.
// Signals:
//   clear_req/clear_ack              new-game clear
//   score_req/score_amt/score_ack    add score_amt points
//   life_req/life_inc/life_ack       life +1 (life_inc=1) or -1 (life_inc=0)
//   lvl_req/lvl_ack                  level +1
// Modports: master = requester side, slave = status_ctrl side.
interface status_ctrl_if;

    logic       clear_req;
    logic       clear_ack;
    logic       score_req;
    logic [7:0] score_amt;
    logic       score_ack;
    logic       life_req;
    logic       life_inc;
    logic       life_ack;
    logic       lvl_req;
    logic       lvl_ack;

    modport master (
        output clear_req, score_req, score_amt, life_req, life_inc, lvl_req,
        input  clear_ack, score_ack, life_ack, lvl_ack
    );

    modport slave (
        input  clear_req, score_req, score_amt, life_req, life_inc, lvl_req,
        output clear_ack, score_ack, life_ack, lvl_ack
    );

endinterface

// File: rtl/status_rr_arbiter.sv
// status_rr_arbiter: combinational round-robin arbiter over score/life/level requests.
// Ports:
//   req       in   3  request vector, bit index = req_idx_e
//   ptr       in   2  requester with highest priority this round
//   grant     out  3  one-hot grant (all zero when no request)
//   ptr_next  out  2  requester after the granted one (ptr when no request)
module status_rr_arbiter
    import status_pkg::*;
(
    input  logic [2:0] req,
    input  req_idx_e   ptr,
    output logic [2:0] grant,
    output req_idx_e   ptr_next
);

    req_idx_e c1, c2, sel;

    always_comb begin
        c1       = rr_step(ptr);
        c2       = rr_step(c1);
        sel      = req[ptr] ? ptr : (req[c1] ? c1 : c2);
        grant    = (|req) ? (3'b001 << sel) : 3'b000;
        ptr_next = (|req) ? rr_step(sel) : ptr;
    end

endmodule

// File: rtl/status_ctrl.sv
// status_ctrl: owns score/life/level for the status overlay; arbitrates update
// requests over a 4-phase req/ack handshake and commits to the display outputs
// only on the vsync rising edge so digits never change mid-frame.
// Ports:
//   clk        in        system clock
//   rst        in        asynchronous active-low reset
//   vsync_in   in        vsync; registered rising edge is the commit point
//   req_if     slave     clear/score/life/level req/ack handshakes
//   score/life/lvl  out  committed 13-bit values
//   game_over  out       committed game-over flag
//   busy       out       FSM not idle
// Build option: BONUS_LIFE_EN adds a bonus life every BONUS_STEP points.
module status_ctrl
    import status_pkg::*;
#(
    parameter int unsigned SCORE_MAX  = 999,
    parameter int unsigned LIFE_INIT  = 3,
    parameter int unsigned LIFE_MAX   = 9,
    parameter int unsigned LVL_INIT   = 1,
`ifdef BONUS_LIFE_EN
    parameter int unsigned BONUS_STEP = 100,
`endif
    parameter int unsigned LVL_MAX    = 99
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                vsync_in,
    status_ctrl_if.slave        req_if,
    output logic [STATUS_W-1:0] score,
    output logic [STATUS_W-1:0] life,
    output logic [STATUS_W-1:0] lvl,
    output logic                game_over,
    output logic                busy
);

    localparam logic [STATUS_W-1:0] SMAX  = STATUS_W'(SCORE_MAX);
    localparam logic [STATUS_W-1:0] LINIT = STATUS_W'(LIFE_INIT);
    localparam logic [STATUS_W-1:0] LMAX  = STATUS_W'(LIFE_MAX);
    localparam logic [STATUS_W-1:0] VINIT = STATUS_W'(LVL_INIT);
    localparam logic [STATUS_W-1:0] VMAX  = STATUS_W'(LVL_MAX);
    localparam logic [STATUS_W-1:0] ONE   = STATUS_W'(1);

    logic [1:0]          state;
    logic [3:0]          gnt;
    logic                ack_q;
    logic                vsync_q;
    req_idx_e            ptr;
    req_idx_e            ptr_next;
    logic [2:0]          arb_grant;
    logic [STATUS_W-1:0] w_score;
    logic [STATUS_W-1:0] w_life;
    logic [STATUS_W-1:0] w_lvl;
    logic                w_go;
    logic [STATUS_W-1:0] score_sum;
    logic [STATUS_W-1:0] score_new;
    logic [STATUS_W-1:0] life_up;
    logic [STATUS_W-1:0] life_dn;
    logic [STATUS_W-1:0] lvl_up;
    logic [3:0]          reqs;
    logic                gnt_req;
    logic                commit;
    logic                bonus_hit;

    // gnt bit order: {clear, lvl, life, score}
    assign reqs = {req_if.clear_req, req_if.lvl_req, req_if.life_req, req_if.score_req};

    status_rr_arbiter u_arb (
        .req      (reqs[2:0]),
        .ptr      (ptr),
        .grant    (arb_grant),
        .ptr_next (ptr_next)
    );

    always_comb begin
        score_sum = w_score + STATUS_W'(req_if.score_amt);
        score_new = (score_sum > SMAX) ? SMAX : score_sum;
        life_up   = (w_life >= LMAX) ? LMAX : w_life + ONE;
        life_dn   = (w_life == '0) ? '0 : w_life - ONE;
        lvl_up    = (w_lvl >= VMAX) ? VMAX : w_lvl + ONE;
        gnt_req   = |(gnt & reqs);
        commit    = vsync_in & ~vsync_q;
    end

`ifdef BONUS_LIFE_EN
    localparam logic [STATUS_W-1:0] BSTEP = STATUS_W'(BONUS_STEP);
    logic [STATUS_W-1:0] next_bonus;
    // A score already pinned at the maximum earns no further bonus.
    assign bonus_hit = (w_score != SMAX) && (score_new >= next_bonus);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            next_bonus <= BSTEP;
        else if (state == ST_EXEC && gnt[3])
            next_bonus <= BSTEP;
        else if (state == ST_EXEC && gnt[0] && !w_go && bonus_hit)
            next_bonus <= next_bonus + BSTEP;
    end
`else
    assign bonus_hit = 1'b0;
`endif

    assign busy              = (state != ST_IDLE);
    assign req_if.score_ack  = ack_q & gnt[0];
    assign req_if.life_ack   = ack_q & gnt[1];
    assign req_if.lvl_ack    = ack_q & gnt[2];
    assign req_if.clear_ack  = ack_q & gnt[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            ack_q     <= 1'b0;
            vsync_q   <= 1'b0;
            ptr       <= REQ_SCORE;
            w_score   <= '0;
            w_life    <= LINIT;
            w_lvl     <= VINIT;
            w_go      <= 1'b0;
            score     <= '0;
            life      <= LINIT;
            lvl       <= VINIT;
            game_over <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            // Nonblocking reads here see pre-EXEC working values, so a
            // coinciding update shows up only at the following vsync.
            if (commit) begin
                score     <= w_score;
                life      <= w_life;
                lvl       <= w_lvl;
                game_over <= w_go;
            end
            if (state == ST_IDLE) begin
                if (|reqs) begin
                    gnt   <= req_if.clear_req ? 4'b1000 : {1'b0, arb_grant};
                    ptr   <= req_if.clear_req ? ptr : ptr_next;
                    state <= ST_EXEC;
                end
            end else if (state == ST_EXEC) begin
                state <= ST_ACK;
                if (gnt[3]) begin
                    w_score <= '0;
                    w_life  <= LINIT;
                    w_lvl   <= VINIT;
                    w_go    <= 1'b0;
                end else if (!w_go) begin
                    if (gnt[0])
                        w_score <= score_new;
                    if (gnt[0] && bonus_hit)
                        w_life <= life_up;
                    if (gnt[1]) begin
                        w_life <= req_if.life_inc ? life_up : life_dn;
                        w_go   <= ~req_if.life_inc & (life_dn == '0);
                    end
                    if (gnt[2])
                        w_lvl <= lvl_up;
                end
            end else begin
                // Raise ack one cycle after EXEC; release once the requester lets go.
                ack_q <= gnt_req;
                state <= gnt_req ? ST_ACK : ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_status_ctrl.sv
// tb_status_ctrl: directed self-checking bench for status_ctrl.
module tb_status_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync_in = 1'b0;
    logic [12:0] score;
    logic [12:0] life;
    logic [12:0] lvl;
    logic        game_over;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    int          who;
    int          exp_bonus_life;

    status_ctrl_if bus();

    status_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vsync_in  (vsync_in),
        .req_if    (bus),
        .score     (score),
        .life      (life),
        .lvl       (lvl),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int id);
        return id == 0 ? bus.score_ack : id == 1 ? bus.life_ack : id == 2 ? bus.lvl_ack : bus.clear_ack;
    endfunction

    function automatic int any_ack();
        return bus.score_ack ? 0 : bus.life_ack ? 1 : bus.lvl_ack ? 2 : bus.clear_ack ? 3 : -1;
    endfunction

    task automatic set_req(input int id, input logic v);
        if (id == 0) bus.score_req = v;
        else if (id == 1) bus.life_req = v;
        else if (id == 2) bus.lvl_req = v;
        else bus.clear_req = v;
    endtask

    // Full handshake for one requester; checks ack latency and release.
    task automatic service(input int id, input logic [7:0] amt, input logic inc);
        int n;
        @(negedge clk);
        bus.score_amt = amt;
        bus.life_inc = inc;
        set_req(id, 1'b1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack_of(id) && n < 10);
        check("ack_latency", n, 3);
        @(negedge clk);
        set_req(id, 1'b0);
        @(posedge clk);
        #1;
        check("ack_release", {ack_of(id), busy}, 0);
    endtask

    // Wait for whichever ack comes next, then complete that handshake.
    task automatic serve_next(output int which);
        int n;
        n = 0;
        which = -1;
        while (which < 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            which = any_ack();
        end
        if (which >= 0) begin
            @(negedge clk);
            set_req(which, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        vsync_in = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vsync_in = 1'b0;
    endtask

    task automatic check_vals(input string tag, input int s, input int l, input int v, input int g);
        check({tag, "_score"}, score, s);
        check({tag, "_life"}, life, l);
        check({tag, "_lvl"}, lvl, v);
        check({tag, "_go"}, game_over, g);
    endtask

    initial begin
        bus.clear_req = 0;
        bus.score_req = 0;
        bus.score_amt = 0;
        bus.life_req = 0;
        bus.life_inc = 0;
        bus.lvl_req = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acks", {bus.clear_ack, bus.score_ack, bus.life_ack, bus.lvl_ack, busy}, 0);
        check_vals("rst", 0, 3, 1, 0);
        @(negedge clk);
        rst = 1;
        pulse_vsync();
        check_vals("rst_vs", 0, 3, 1, 0);

        service(0, 8'd25, 1'b0);
        check("pre_vsync_score", score, 0);
        pulse_vsync();
        check("score25", score, 25);

        service(0, 8'd255, 1'b0);
        service(0, 8'd255, 1'b0);
        service(0, 8'd255, 1'b0);
        service(0, 8'd200, 1'b0);
        pulse_vsync();
        check("score990", score, 990);
        service(0, 8'd50, 1'b0);
        pulse_vsync();
        check("score_sat", score, 999);
`ifdef BONUS_LIFE_EN
        check("bonus_chain_life", life, 8);
`else
        check("no_bonus_life", life, 3);
`endif

        service(3, 8'd0, 1'b0);
        pulse_vsync();
        check_vals("clear", 0, 3, 1, 0);

        for (int i = 0; i < 100; i++) service(2, 8'd0, 1'b0);
        pulse_vsync();
        check("lvl_sat", lvl, 99);

        for (int i = 0; i < 7; i++) service(1, 8'd0, 1'b1);
        pulse_vsync();
        check("life_sat", life, 9);

        service(3, 8'd0, 1'b0);
        service(1, 8'd0, 1'b0);
        service(1, 8'd0, 1'b0);
        pulse_vsync();
        check_vals("life1", 0, 1, 1, 0);
        service(1, 8'd0, 1'b0);
        pulse_vsync();
        check_vals("go", 0, 0, 1, 1);
        service(0, 8'd10, 1'b0);
        service(2, 8'd0, 1'b0);
        service(1, 8'd0, 1'b0);
        pulse_vsync();
        check_vals("go_frozen", 0, 0, 1, 1);

        service(3, 8'd0, 1'b0);
        pulse_vsync();
        check_vals("clear2", 0, 3, 1, 0);

        // vsync rising edge lands on the EXEC edge: commit sees pre-update value.
        @(negedge clk);
        bus.score_amt = 8'd7;
        bus.score_req = 1;
        @(negedge clk);
        vsync_in = 1;
        @(posedge clk);
        #1;
        check("commit_vs_exec", score, 0);
        @(negedge clk);
        vsync_in = 0;
        serve_next(who);
        check("commit_vs_exec_ack", who, 0);
        pulse_vsync();
        check("commit_late", score, 7);

        service(3, 8'd0, 1'b0);
        service(0, 8'd95, 1'b0);
        service(0, 8'd10, 1'b0);
        pulse_vsync();
        check("bonus_score105", score, 105);
`ifdef BONUS_LIFE_EN
        exp_bonus_life = 4;
`else
        exp_bonus_life = 3;
`endif
        check("bonus_life1", life, exp_bonus_life);
        service(0, 8'd100, 1'b0);
        pulse_vsync();
        check("bonus_score205", score, 205);
        check("bonus_life2", life, exp_bonus_life + (exp_bonus_life == 4 ? 1 : 0));

        // Round-robin from reset: score, life, lvl.
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        bus.score_amt = 8'd5;
        bus.life_inc = 1;
        bus.score_req = 1;
        bus.life_req = 1;
        bus.lvl_req = 1;
        serve_next(who);
        check("rr_first", who, 0);
        serve_next(who);
        check("rr_second", who, 1);
        serve_next(who);
        check("rr_third", who, 2);
        pulse_vsync();
        check_vals("rr", 5, 4, 2, 0);

        // Clear beats everything; pointer untouched so score follows.
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        bus.clear_req = 1;
        bus.score_req = 1;
        bus.life_req = 1;
        bus.lvl_req = 1;
        serve_next(who);
        check("prio_clear", who, 3);
        serve_next(who);
        check("prio_then_score", who, 0);
        serve_next(who);
        check("prio_then_life", who, 1);
        serve_next(who);
        check("prio_then_lvl", who, 2);

        // Reset in the middle of a handshake drops ack at once.
        @(negedge clk);
        bus.score_req = 1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_ack_up", bus.score_ack, 1);
        rst = 0;
        #1;
        check("mid_rst_ack", {bus.score_ack, busy}, 0);
        bus.score_req = 0;
        @(negedge clk);
        rst = 1;
        pulse_vsync();
        check_vals("mid_rst", 0, 3, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_ctrl.md
Name: status_ctrl

Overview:
- Owns the game status values (score, life, level) shown by the on-screen numeric status overlay.
- Accepts update requests from three game-logic requesters plus a new-game clear, and arbitrates them round-robin over a 4-phase req/ack handshake.
- Applies saturating arithmetic to working registers.
- Commits working values to the display-facing outputs only at the vsync rising edge, so digits never change mid-frame.

Parameters:
- SCORE_MAX, 999, score saturation value (3-digit display).
- LIFE_INIT, 3, life value after reset/clear.
- LIFE_MAX, 9, life saturation value.
- LVL_INIT, 1, level value after reset/clear.
- LVL_MAX, 99, level saturation value.
- BONUS_STEP, 100, score interval per bonus life (used only with BONUS_LIFE_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- vsync_in  in  1  vsync from the timing chain; rising edge = commit point.
- clear_req  in  1  new-game request; highest priority.
- clear_ack  out  1  ack for clear_req.
- score_req  in  1  add-to-score request.
- score_amt  in  8  points to add; held stable while score_req is high.
- score_ack  out  1  ack for score_req.
- life_req  in  1  life change request.
- life_inc  in  1  1 = +1 life, 0 = -1 life; held stable with life_req.
- life_ack  out  1  ack for life_req.
- lvl_req  in  1  level +1 request.
- lvl_ack  out  1  ack for lvl_req.
- score  out  13  committed score, to the overlay.
- life  out  13  committed life, to the overlay.
- lvl  out  13  committed level, to the overlay.
- game_over  out  1  committed flag; set when life reaches 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, async):
  - working and committed score = 0, life = LIFE_INIT, lvl = LVL_INIT.
  - game_over = 0, all acks = 0, busy = 0.
  - FSM = IDLE, round-robin pointer = score, vsync edge register = 0.
- FSM states: IDLE, EXEC, ACK.
  - IDLE: on a clock edge with any req high, latch grant and go to EXEC.
  - Grant rule: clear_req wins unconditionally. Otherwise round-robin among score, life, lvl, starting from the pointer; the pointer moves to the requester after the one granted.
  - EXEC (1 cycle): update working registers for the granted requester; go to ACK.
  - ACK: granted ack is high. Stay until the granted req is low, then drop ack and return to IDLE.
  - Timing: req seen at edge N, ack visible after edge N+2. Minimum of 4 cycles between services of the same requester.
- Arithmetic (13-bit unsigned, all saturating):
  - score = min(score + score_amt, SCORE_MAX).
  - life +1: min(life + 1, LIFE_MAX).
  - life -1: max(life - 1, 0). Reaching 0 sets working game_over.
  - lvl = min(lvl + 1, LVL_MAX).
- While working game_over = 1: score, life and lvl requests are still handshaken, but the registers do not change.
- Clear: working registers go to their reset values and game_over clears. The round-robin pointer is unchanged.
- Commit: vsync_in is registered; a rising edge (prev = 0, now = 1) copies working → committed, including game_over.
- Commit coinciding with an EXEC update: the commit takes the pre-update working values. The update becomes visible at the next vsync.
- A req dropped before it is granted is simply not serviced; no error is raised.
- Reset mid-handshake: FSM returns to IDLE and acks drop immediately. Requesters must re-request.

Optional Feature:
- Macro: BONUS_LIFE_EN.
- Defined: adds a next_bonus threshold register (reset/clear value BONUS_STEP).
  - In a score EXEC where the new score ≥ next_bonus: life = min(life + 1, LIFE_MAX) and next_bonus += BONUS_STEP, in the same cycle.
  - At most one bonus is awarded per request.
  - Once score saturates at SCORE_MAX, no further bonus is awarded.
- Undefined: no threshold register; score updates never change life.

Decomposition:
- Shared package status_pkg:
  - status value width constant (13).
  - FSM state enum.
  - requester index enum (REQ_SCORE, REQ_LIFE, REQ_LVL).
- One natural sub-module: status_rr_arbiter. Inputs: 3-bit request vector plus pointer. Outputs: one-hot grant and next pointer.

Test Plan:
- Reset, then pulse vsync_in → score = 0, life = 3, lvl = 1, game_over = 0; all acks 0.
- score_req with score_amt = 25, held to ack, then vsync rising edge → score = 25. Before that vsync, score stays 0.
- score = 990, add 50 → working score 999 (saturated), committed after vsync.
- Three life_req with life_inc = 0 from life = 3, then vsync → life = 0, game_over = 1. A following score_req of 10 is acked and score is unchanged.
- score, life and lvl requests all raised together from reset (pointer = score) → acks in order score, life, lvl. With clear_req also high, clear is served first.
- BONUS_LIFE_EN defined: score 95 + 10 → score 105, life 4, next_bonus 200. Then +100 → score 205, life 5.
